// File: rtl/pinmux_pkg.sv
// Shared types and constants for the GPIO pin-multiplexing controller.
package pinmux_pkg;

    typedef enum logic [1:0] {
        FN_GPIO  = 2'd0,
        FN_ALT_A = 2'd1,
        FN_ALT_B = 2'd2,
        FN_OFF   = 2'd3
    } func_e;

    typedef enum logic {
        ST_IDLE,
        ST_ISOLATE
    } state_e;

    localparam int TA_W  = 4;
    localparam int SEL_W = 48;

    localparam logic [1:0] REG_SEL_LO = 2'd0;
    localparam logic [1:0] REG_SEL_HI = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

endpackage

// File: rtl/pinmux_pad_cell.sv
// Combinational per-pad mux: routes one of three owners to the pad.
// Isolation or OFF tristates the pad and idles alternate inputs high.
module pinmux_pad_cell
    import pinmux_pkg::*;
(
    input  func_e func_i,
    input  logic  iso_i,
    input  logic  gpio_o_i,
    input  logic  gpio_oen_i,
    input  logic  alta_o_i,
    input  logic  alta_oen_i,
    input  logic  altb_o_i,
    input  logic  altb_oen_i,
    input  logic  pad_c_i,
    output logic  pad_o_o,
    output logic  pad_oen_o,
    output logic  alta_i_o,
    output logic  altb_i_o
);

    always_comb begin
        pad_o_o   = 1'b0;
        pad_oen_o = 1'b1;
        alta_i_o  = 1'b1;
        altb_i_o  = 1'b1;
        if (!iso_i) begin
            unique case (func_i)
                FN_GPIO: begin
                    pad_o_o   = gpio_o_i;
                    pad_oen_o = gpio_oen_i;
                end
                FN_ALT_A: begin
                    pad_o_o   = alta_o_i;
                    pad_oen_o = alta_oen_i;
                    alta_i_o  = pad_c_i;
                end
                FN_ALT_B: begin
                    pad_o_o   = altb_o_i;
                    pad_oen_o = altb_oen_i;
                    altb_i_o  = pad_c_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gpio_pinmux_ctrl.sv
// Wishbone-configured pad pin-mux with a break-before-make sequencer
// that isolates only the pads whose function is changing.
module gpio_pinmux_ctrl
    import pinmux_pkg::*;
#(
    parameter int N_PADS   = 24,
    parameter int TA_RESET = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    input  logic [N_PADS-1:0] gpio_o,
    input  logic [N_PADS-1:0] gpio_oen,
    output logic [N_PADS-1:0] gpio_i,
    input  logic [N_PADS-1:0] alta_o,
    input  logic [N_PADS-1:0] alta_oen,
    input  logic [N_PADS-1:0] altb_o,
    input  logic [N_PADS-1:0] altb_oen,
    output logic [N_PADS-1:0] alta_i,
    output logic [N_PADS-1:0] altb_i,
    output logic [N_PADS-1:0] pad_o,
    output logic [N_PADS-1:0] pad_oen,
    input  logic [N_PADS-1:0] pad_c
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   active_q, active_d;
    logic [SEL_W-1:0]   pend_q, pend_d;
    logic [N_PADS-1:0]  mask_q, mask_d;
    logic [TA_W-1:0]    cnt_q, cnt_d;
    logic [TA_W-1:0]    ta_q, ta_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;

    logic               valid;
    logic               sel_wr;
    logic               stall;
    logic               busy;
    logic [1:0]         idx;
    logic [SEL_W-1:0]   pend_wr;
    logic [N_PADS-1:0]  diff;
    logic [31:0]        rdata;
    logic               unused_adr;

    assign unused_adr = &{1'b0, wb_adr_i[1:0]};

    assign idx    = wb_adr_i[3:2];
    assign valid  = wb_cyc_i & wb_stb_i & ~ack_q;
    assign sel_wr = valid & wb_we_i &
                    ((idx == REG_SEL_LO) | (idx == REG_SEL_HI));
    assign busy   = (state_q == ST_ISOLATE);
    assign stall  = sel_wr & busy;

    always_comb begin
        pend_wr = pend_q;
        if (idx == REG_SEL_LO) pend_wr[31:0] = wb_dat_i;
        else                   pend_wr[47:32] = wb_dat_i[15:0];
    end

    always_comb begin
        diff = '0;
        for (int k = 0; k < N_PADS; k++) begin
            diff[k] = (pend_wr[2*k +: 2] != active_q[2*k +: 2]);
        end
    end

    always_comb begin
        rdata = '0;
        unique case (idx)
            REG_SEL_LO: rdata = pend_q[31:0];
            REG_SEL_HI: rdata = {16'b0, pend_q[47:32]};
            REG_CTRL:   rdata = {{(32-TA_W){1'b0}}, ta_q};
            REG_STATUS: rdata = {31'b0, busy};
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        pend_d   = pend_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        ta_d     = ta_q;
        ack_d    = 1'b0;
        dat_d    = dat_q;

        if (valid && !stall) begin
            ack_d = 1'b1;
            if (!wb_we_i) dat_d = rdata;
            else if (idx == REG_CTRL) ta_d = wb_dat_i[TA_W-1:0];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (sel_wr) begin
                    pend_d = pend_wr;
                    if (diff != '0) begin
                        mask_d  = diff;
                        cnt_d   = ta_q;
                        state_d = ST_ISOLATE;
                    end
                end
            end
            ST_ISOLATE: begin
                if (cnt_q == '0) begin
                    active_d = pend_q;
                    mask_d   = '0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - TA_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            active_q <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            ta_q     <= TA_W'(TA_RESET);
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            ta_q     <= ta_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign gpio_i   = pad_c;

    for (genvar k = 0; k < N_PADS; k++) begin : g_pad
        pinmux_pad_cell u_cell (
            .func_i     (func_e'(active_q[2*k +: 2])),
            .iso_i      (mask_q[k]),
            .gpio_o_i   (gpio_o[k]),
            .gpio_oen_i (gpio_oen[k]),
            .alta_o_i   (alta_o[k]),
            .alta_oen_i (alta_oen[k]),
            .altb_o_i   (altb_o[k]),
            .altb_oen_i (altb_oen[k]),
            .pad_c_i    (pad_c[k]),
            .pad_o_o    (pad_o[k]),
            .pad_oen_o  (pad_oen[k]),
            .alta_i_o   (alta_i[k]),
            .altb_i_o   (altb_i[k])
        );
    end

endmodule

// File: tb/tb_gpio_pinmux_ctrl.sv
// Directed bench for gpio_pinmux_ctrl: register table plus
// hand-written sequencer, stall and reset sequences.
module tb_gpio_pinmux_ctrl;

    localparam int N = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]    wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic [N-1:0]  gpio_o, gpio_oen, gpio_i;
    logic [N-1:0]  alta_o, alta_oen, altb_o, altb_oen;
    logic [N-1:0]  alta_i, altb_i;
    logic [N-1:0]  pad_o, pad_oen, pad_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gpio_pinmux_ctrl #(.N_PADS(N), .TA_RESET(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .gpio_o   (gpio_o),
        .gpio_oen (gpio_oen),
        .gpio_i   (gpio_i),
        .alta_o   (alta_o),
        .alta_oen (alta_oen),
        .altb_o   (altb_o),
        .altb_oen (altb_oen),
        .alta_i   (alta_i),
        .altb_i   (altb_i),
        .pad_o    (pad_o),
        .pad_oen  (pad_oen),
        .pad_c    (pad_c)
    );

    typedef struct {
        logic [3:0]  adr;
        logic        we;
        logic [31:0] dat;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wb(input logic [3:0] adr, input logic we,
                      input logic [31:0] dat, output logic [31:0] rd,
                      output int cyc);
        if (wb_ack_o) begin
            @(posedge clk); #1;
        end
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!wb_ack_o && cyc < 40);
        rd = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wr(input string name, input logic [3:0] adr,
                      input logic [31:0] dat, input int exp_cyc);
        logic [31:0] rd;
        int cyc;
        wb(adr, 1'b1, dat, rd, cyc);
        chk(name, cyc, exp_cyc);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] adr,
                          input logic [31:0] exp);
        logic [31:0] rd;
        int cyc;
        wb(adr, 1'b0, 32'h0, rd, cyc);
        chk({name, "_lat"}, cyc, 1);
        chk(name, rd, exp);
    endtask

    // Counts isolated cycles on pad k while pad 1 (GPIO) keeps toggling.
    task automatic count_iso(input int k, output int n, output bit ok);
        n = 0;
        ok = 1'b1;
        while (pad_oen[k] && n < 40) begin
            n++;
            if (pad_o[k] !== 1'b0 || alta_i[k] !== 1'b1 ||
                altb_i[k] !== 1'b1) ok = 1'b0;
            gpio_o[1] = ~gpio_o[1];
            #2;
            if (pad_o[1] !== gpio_o[1] || pad_oen[1] !== 1'b0) ok = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int cyc;
        int n;
        bit ok;

        tbl[0]  = '{4'h0, 1'b0, 32'h0,         32'h0, "rst_sel_lo"};
        tbl[1]  = '{4'h4, 1'b0, 32'h0,         32'h0, "rst_sel_hi"};
        tbl[2]  = '{4'h8, 1'b0, 32'h0,         32'h2, "rst_ctrl"};
        tbl[3]  = '{4'hC, 1'b0, 32'h0,         32'h0, "rst_status"};
        tbl[4]  = '{4'h8, 1'b1, 32'hFFFF_FFF7, 32'h0, "wr_ctrl7"};
        tbl[5]  = '{4'h8, 1'b0, 32'h0,         32'h7, "rd_ctrl7"};
        tbl[6]  = '{4'hC, 1'b1, 32'hFFFF_FFFF, 32'h0, "wr_status"};
        tbl[7]  = '{4'hC, 1'b0, 32'h0,         32'h0, "rd_status_ro"};
        tbl[8]  = '{4'h4, 1'b1, 32'hFFFF_0000, 32'h0, "wr_hi_same"};
        tbl[9]  = '{4'h4, 1'b0, 32'h0,         32'h0, "rd_hi_same"};
        tbl[10] = '{4'hC, 1'b0, 32'h0,         32'h0, "rd_status_same"};
        tbl[11] = '{4'h8, 1'b1, 32'h2,         32'h0, "wr_ctrl2"};
        tbl[12] = '{4'h8, 1'b0, 32'h0,         32'h2, "rd_ctrl2"};

        reset    = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        gpio_o   = 24'hA5A5A5;
        gpio_oen = '0;
        alta_o   = 24'h123456;
        alta_oen = '0;
        altb_o   = 24'h654321;
        altb_oen = '0;
        pad_c    = 24'hFFFFFF;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;

        chk("rst_ack", wb_ack_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_pad_o", pad_o, 24'hA5A5A5);
        chk("rst_pad_oen", pad_oen, 0);
        chk("rst_alta_i", alta_i, 24'hFFFFFF);
        chk("rst_altb_i", altb_i, 24'hFFFFFF);
        pad_c = 24'h0F0F0E;
        #1;
        chk("gpio_i_route", gpio_i, 24'h0F0F0E);
        chk("alta_i_idle", alta_i, 24'hFFFFFF);

        for (int i = 0; i < 13; i++) begin
            wb(tbl[i].adr, tbl[i].we, tbl[i].dat, rd, cyc);
            chk({tbl[i].name, "_lat"}, cyc, 1);
            if (!tbl[i].we) chk(tbl[i].name, rd, tbl[i].exp);
        end

        // pad0 -> ALT_A with TA=2: three isolated cycles
        wr("sel_a_lat", 4'h0, 32'h1, 1);
        count_iso(0, n, ok);
        chk("iso_len_ta2", n, 3);
        chk("iso_no_glitch", ok, 1);
        chk("p0_alt_a_lo", pad_o[0], alta_o[0]);
        alta_o[0] = 1'b1;
        #1;
        chk("p0_alt_a_hi", pad_o[0], 1);
        chk("p0_alta_i", alta_i[0], 0);
        rd_chk("rd_sel_lo_1", 4'h0, 32'h1);

        // long isolation: STATUS read, TA rewrite and stalled SEL write
        wr("ctrl6", 4'h8, 32'h6, 1);
        wr("sel_gpio_lat", 4'h0, 32'h0, 1);
        rd_chk("status_busy", 4'hC, 32'h1);
        wr("ctrl0_in_iso", 4'h8, 32'h0, 1);
        wr("sel_stall_lat", 4'h0, 32'h800, 3);
        chk("p0_back_gpio", pad_oen[0], 0);
        count_iso(5, n, ok);
        chk("iso_len_ta0", n, 1);
        chk("iso_ta0_glitch", ok, 1);
        chk("p5_altb_i", altb_i[5], 0);
        chk("p5_alta_i", alta_i[5], 1);
        chk("p5_gpio_i", gpio_i[5], 0);
        chk("p5_pad_o", pad_o[5], altb_o[5]);
        altb_oen[5] = 1'b1;
        #1;
        chk("p5_pad_oen", pad_oen[5], 1);
        altb_oen[5] = 1'b0;
        rd_chk("rd_sel_lo_800", 4'h0, 32'h800);

        // pad5 OFF
        wr("sel_off_lat", 4'h0, 32'hC00, 1);
        @(posedge clk); #1;
        chk("p5_off_oen", pad_oen[5], 1);
        chk("p5_off_o", pad_o[5], 0);
        chk("p5_off_altb_i", altb_i[5], 1);

        // pad16 OFF, then same-value rewrite with a long TA
        wr("hi_off_lat", 4'h4, 32'h3, 1);
        @(posedge clk); #1;
        chk("p16_off_oen", pad_oen[16], 1);
        chk("p16_off_o", pad_o[16], 0);
        rd_chk("status_after_hi", 4'hC, 32'h0);
        wr("ctrl5", 4'h8, 32'h5, 1);
        wr("hi_same_lat", 4'h4, 32'h3, 1);
        rd_chk("status_no_busy", 4'hC, 32'h0);
        rd_chk("rd_sel_hi_3", 4'h4, 32'h3);

        // reset in the middle of an isolation
        wr("sel_pre_rst", 4'h0, 32'h1, 1);
        chk("iso_pre_rst", pad_oen[0], 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("post_rst_ack", wb_ack_o, 0);
        chk("post_rst_pad_o", pad_o, gpio_o);
        chk("post_rst_pad_oen", pad_oen, 0);
        rd_chk("post_rst_status", 4'hC, 32'h0);
        rd_chk("post_rst_sel_lo", 4'h0, 32'h0);
        rd_chk("post_rst_sel_hi", 4'h4, 32'h0);
        rd_chk("post_rst_ctrl", 4'h8, 32'h2);
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_hold_o", pad_o, gpio_o);
        chk("post_rst_hold_oen", pad_oen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
